ps2_mouse_decoder: RTL and testbench

- Receive-only PS/2 mouse front end, directly upstream of the CPU core.
- Deserialises the PS/2 clock/data line into 3-byte stream-mode packets.
- Accumulates signed deltas into a clamped absolute cursor position.
- Presents mouse_x, mouse_y, left_click, right_click and a data_ready strobe. The core reads these through its register file.

---
 rtl/ps2_mouse_decoder_if.sv | 22 ++
 rtl/ps2_mouse_decoder.sv | 175 +++++++++++++++++
 tb/tb_ps2_mouse_decoder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_decoder_if.sv
// Signal bundle between the PS/2 mouse decoder and its surroundings:
// the raw PS/2 line on one side, the cursor/button view for the core on the other.
interface ps2_mouse_decoder_if;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] mouse_x;
   logic [15:0] mouse_y;
   logic        left_click;
   logic        right_click;
   logic        data_ready;
   logic        frame_error;

   modport master (
      input  ps2_clk, ps2_data,
      output mouse_x, mouse_y, left_click, right_click, data_ready, frame_error
   );

   modport slave (
      output ps2_clk, ps2_data,
      input  mouse_x, mouse_y, left_click, right_click, data_ready, frame_error
   );
endinterface

// File: rtl/ps2_mouse_decoder.sv
// Receive-only PS/2 mouse front end: filters the line, deframes 11-bit bytes,
// assembles 3-byte stream packets and integrates them into a clamped cursor.
//
// state   | meaning
// S_IDLE  | waiting for a start bit (data low on a filtered falling edge)
// S_RECV  | shifting data, parity and stop bits; watchdog running
// S_CHECK | one cycle: judge parity/stop and file the byte into the packet
// S_APPLY | one cycle: integrate deltas, update buttons, pulse data_ready
module ps2_mouse_decoder #(
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input logic                  clk,
   input logic                  reset,
   ps2_mouse_decoder_if.master  bus
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0] FILT_LOAD = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TOUT_LOAD = TW'(TIMEOUT - 1);
   localparam logic signed [16:0] X_MAX = 17'(SCREEN_W - 1);
   localparam logic signed [16:0] Y_MAX = 17'(SCREEN_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK, S_APPLY} state_t;
   state_t state, state_nxt;

   logic [1:0]    clk_sync, data_sync;
   logic [FW-1:0] filt_cnt;
   logic          clk_filt, clk_filt_d;
   logic          sample_evt, data_bit;
   logic [TW-1:0] tout_cnt;
   logic          tout_hit;
   logic [3:0]    bit_cnt;
   logic [1:0]    byte_idx;
   logic [7:0]    shreg;
   logic          parity_bit, stop_bit, good;
   logic          btn_l, btn_r, x_sign, y_sign, x_ovf, y_ovf;
   logic [7:0]    dx_byte, dy_byte;
   logic signed [16:0] dx, dy, x_sum, y_sum;
   logic [15:0]   x_new, y_new;

   assign sample_evt = clk_filt_d & ~clk_filt;
   assign data_bit   = data_sync[1];
   assign tout_hit   = (state == S_RECV) && !sample_evt && (tout_cnt == '0);
   assign good       = (^{shreg, parity_bit}) & stop_bit;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync   <= '1;
         data_sync  <= '1;
         filt_cnt   <= FILT_LOAD;
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
      end else begin
         clk_sync   <= {clk_sync[0], bus.ps2_clk};
         data_sync  <= {data_sync[0], bus.ps2_data};
         clk_filt_d <= clk_filt;
         // level flips only after FILTER_LEN consecutive disagreeing samples
         if (clk_sync[1] == clk_filt) begin
            filt_cnt <= FILT_LOAD;
         end else if (filt_cnt == '0) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= FILT_LOAD;
         end else begin
            filt_cnt <= filt_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (sample_evt && !data_bit) state_nxt = S_RECV;
         S_RECV:  if (sample_evt && bit_cnt == 4'd10) state_nxt = S_CHECK;
                  else if (tout_hit)                  state_nxt = S_IDLE;
         S_CHECK: state_nxt = (good && byte_idx == 2'd2) ? S_APPLY : S_IDLE;
         S_APPLY: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      dx    = {{8{x_sign}}, x_sign, dx_byte};
      dy    = {{8{y_sign}}, y_sign, dy_byte};
      x_sum = $signed({1'b0, bus.mouse_x}) + dx;
      y_sum = $signed({1'b0, bus.mouse_y}) - dy;
      if (x_sum < 0)          x_new = '0;
      else if (x_sum > X_MAX) x_new = X_MAX[15:0];
      else                    x_new = x_sum[15:0];
      if (y_sum < 0)          y_new = '0;
      else if (y_sum > Y_MAX) y_new = Y_MAX[15:0];
      else                    y_new = y_sum[15:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt         <= '0;
         byte_idx        <= '0;
         shreg           <= '0;
         parity_bit      <= 1'b0;
         stop_bit        <= 1'b0;
         tout_cnt        <= '0;
         {btn_l, btn_r, x_sign, y_sign, x_ovf, y_ovf} <= '0;
         dx_byte         <= '0;
         dy_byte         <= '0;
         bus.mouse_x     <= 16'(SCREEN_W / 2);
         bus.mouse_y     <= 16'(SCREEN_H / 2);
         bus.left_click  <= 1'b0;
         bus.right_click <= 1'b0;
         bus.data_ready  <= 1'b0;
         bus.frame_error <= 1'b0;
      end else begin
         bus.data_ready  <= 1'b0;
         bus.frame_error <= 1'b0;
         case (state)
            S_IDLE: begin
               tout_cnt <= TOUT_LOAD;
               if (sample_evt && !data_bit) bit_cnt <= 4'd1;
            end
            S_RECV: begin
               if (sample_evt) begin
                  tout_cnt <= TOUT_LOAD;
                  bit_cnt  <= bit_cnt + 4'd1;
                  if (bit_cnt <= 4'd8)       shreg      <= {data_bit, shreg[7:1]};
                  else if (bit_cnt == 4'd9)  parity_bit <= data_bit;
                  else                       stop_bit   <= data_bit;
               end else if (tout_cnt == '0) begin
                  byte_idx <= '0;
               end else begin
                  tout_cnt <= tout_cnt - 1'b1;
               end
            end
            S_CHECK: begin
               bit_cnt <= '0;
               if (!good) begin
                  bus.frame_error <= 1'b1;
                  byte_idx        <= '0;
               end else begin
                  case (byte_idx)
                     2'd0: begin
                        // header without the always-one sync bit: drop it and resync
                        if (!shreg[3]) begin
                           bus.frame_error <= 1'b1;
                        end else begin
                           {y_ovf, x_ovf, y_sign, x_sign} <= shreg[7:4];
                           {btn_r, btn_l}                 <= shreg[1:0];
                           byte_idx <= 2'd1;
                        end
                     end
                     2'd1:    begin dx_byte <= shreg; byte_idx <= 2'd2; end
                     2'd2:    dy_byte <= shreg;
                     default: byte_idx <= '0;
                  endcase
               end
            end
            S_APPLY: begin
               if (!x_ovf) bus.mouse_x <= x_new;
               if (!y_ovf) bus.mouse_y <= y_new;
               bus.left_click  <= btn_l;
               bus.right_click <= btn_r;
               bus.data_ready  <= 1'b1;
               byte_idx        <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Bench for ps2_mouse_decoder: fixed packet table with hand-derived cursor values,
// corner-case sequences, and random packets checked against an arithmetic model.
module tb_ps2_mouse_decoder;
   localparam int HALF = 15;
   localparam int TOUT = 2000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ps2_mouse_decoder_if bus();

   ps2_mouse_decoder #(
      .SCREEN_W(640), .SCREEN_H(480), .FILTER_LEN(8), .TIMEOUT(TOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int dr_cnt = 0, fe_cnt = 0, both_cnt = 0;
   int mx, my, ml, mr;

   typedef struct {
      logic [7:0] b0, b1, b2;
      int ex, ey, el, er;
   } vec_t;
   vec_t vecs[16];

   always @(negedge clk) begin
      if (bus.data_ready) dr_cnt++;
      if (bus.frame_error) fe_cnt++;
      if (bus.data_ready && bus.frame_error) both_cnt++;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      bus.ps2_data = b;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      send_bit(1'b1);
      bus.ps2_data = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   function automatic int clamp(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_apply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      int dx, dy;
      dx = b0[4] ? int'(b1) - 256 : int'(b1);
      dy = b0[5] ? int'(b2) - 256 : int'(b2);
      if (!b0[6]) mx = clamp(mx + dx, 639);
      if (!b0[7]) my = clamp(my - dy, 479);
      ml = int'(b0[0]);
      mr = int'(b0[1]);
   endtask

   task automatic packet_check(input string name, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int ex, input int ey,
                               input int el, input int er);
      int d0, f0;
      d0 = dr_cnt;
      f0 = fe_cnt;
      send_frame(b0, 1'b0);
      send_frame(b1, 1'b0);
      send_frame(b2, 1'b0);
      repeat (20) @(negedge clk);
      check({name, "_ready"}, dr_cnt - d0, 1);
      check({name, "_ferr"}, fe_cnt - f0, 0);
      check({name, "_x"}, int'(bus.mouse_x), ex);
      check({name, "_y"}, int'(bus.mouse_y), ey);
      check({name, "_left"}, int'(bus.left_click), el);
      check({name, "_right"}, int'(bus.right_click), er);
   endtask

   task automatic model_packet(input string name, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2);
      model_apply(b0, b1, b2);
      packet_check(name, b0, b1, b2, mx, my, ml, mr);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.ps2_clk = 1'b1;
      bus.ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      mx = 320; my = 240; ml = 0; mr = 0;
   endtask

   task automatic check_home(input string name);
      check({name, "_x"}, int'(bus.mouse_x), 320);
      check({name, "_y"}, int'(bus.mouse_y), 240);
      check({name, "_left"}, int'(bus.left_click), 0);
      check({name, "_right"}, int'(bus.right_click), 0);
   endtask

   initial begin
      int d0, f0;
      logic [7:0] r0, r1, r2;

      vecs[0]  = '{8'h09, 8'h05, 8'h03, 325, 237, 1, 0};
      vecs[1]  = '{8'h1A, 8'hF6, 8'h00, 315, 237, 0, 1};
      vecs[2]  = '{8'h08, 8'hFF, 8'h00, 570, 237, 0, 0};
      vecs[3]  = '{8'h08, 8'h41, 8'h00, 635, 237, 0, 0};
      vecs[4]  = '{8'h08, 8'h14, 8'h00, 639, 237, 0, 0};
      vecs[5]  = '{8'h28, 8'h00, 8'hFD, 639, 240, 0, 0};
      vecs[6]  = '{8'h28, 8'h00, 8'h10, 639, 479, 0, 0};
      vecs[7]  = '{8'h48, 8'h50, 8'h00, 639, 479, 0, 0};
      vecs[8]  = '{8'h18, 8'h00, 8'h00, 383, 479, 0, 0};
      vecs[9]  = '{8'h18, 8'h00, 8'h00, 127, 479, 0, 0};
      vecs[10] = '{8'h18, 8'h00, 8'h00,   0, 479, 0, 0};
      vecs[11] = '{8'h88, 8'h00, 8'h7F,   0, 479, 0, 0};
      vecs[12] = '{8'h08, 8'h00, 8'h7F,   0, 352, 0, 0};
      vecs[13] = '{8'h08, 8'h00, 8'hFF,   0,  97, 0, 0};
      vecs[14] = '{8'h08, 8'h00, 8'hFF,   0,   0, 0, 0};
      vecs[15] = '{8'h0B, 8'h01, 8'h00,   1,   0, 1, 1};

      reset = 1'b1;
      bus.ps2_clk = 1'b1;
      bus.ps2_data = 1'b1;
      do_reset();
      repeat (1000) @(negedge clk);
      check_home("idle");
      check("idle_ready_count", dr_cnt, 0);
      check("idle_ferr_count", fe_cnt, 0);

      for (int i = 0; i < 16; i++)
         packet_check($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2,
                      vecs[i].ex, vecs[i].ey, vecs[i].el, vecs[i].er);

      do_reset();
      repeat (5) @(negedge clk);
      check_home("rst_after_table");

      // header with bad parity, then a clean packet
      d0 = dr_cnt; f0 = fe_cnt;
      send_frame(8'h08, 1'b1);
      repeat (20) @(negedge clk);
      check("parity_ferr", fe_cnt - f0, 1);
      check("parity_ready", dr_cnt - d0, 0);
      model_packet("after_parity", 8'h09, 8'h05, 8'h03);

      // header with sync bit clear
      d0 = dr_cnt; f0 = fe_cnt;
      send_frame(8'h00, 1'b0);
      repeat (20) @(negedge clk);
      check("sync_ferr", fe_cnt - f0, 1);
      check("sync_ready", dr_cnt - d0, 0);
      model_packet("after_sync", 8'h1A, 8'hF6, 8'h00);

      // header plus a stalled partial frame, then a full packet
      f0 = fe_cnt;
      send_frame(8'h09, 1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      bus.ps2_data = 1'b1;
      repeat (TOUT + 10) @(negedge clk);
      check("timeout_ferr", fe_cnt - f0, 0);
      model_packet("after_timeout", 8'h2A, 8'h20, 8'hF0);

      // reset after byte 1 of a packet
      d0 = dr_cnt;
      send_frame(8'h09, 1'b0);
      send_frame(8'h05, 1'b0);
      do_reset();
      repeat (5) @(negedge clk);
      check_home("midpkt_rst");
      check("midpkt_rst_ready", dr_cnt - d0, 0);
      model_packet("after_midpkt_rst", 8'h09, 8'h05, 8'h03);

      for (int i = 0; i < 12; i++) begin
         r0 = 8'($urandom_range(0, 255)) | 8'h08;
         r1 = 8'($urandom_range(0, 255));
         r2 = 8'($urandom_range(0, 255));
         model_packet($sformatf("rand%0d", i), r0, r1, r2);
      end

      check("ready_ferr_overlap", both_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
